// File: rtl/noc_route_decoder.sv
// Clocked two-way NoC route decoder: one flit per cycle is steered to port 0
// or port 1. The route decision is published on a separate select channel.
// Per-port FIFOs decouple the ports, and per-port counters track delivered flits.

// Pointer-based FIFO: log2(D) index bits plus a wrap bit, with the head shown combinationally.
module noc_route_fifo #(
    parameter int unsigned W = 9,
    parameter int unsigned D = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         valid,
    output logic         full
);
    localparam int unsigned AW = $clog2(D);

    logic [W-1:0] mem [D];
    logic [AW:0]  wptr;
    logic [AW:0]  rptr;

    assign valid = (wptr != rptr);
    assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
    assign rdata = mem[rptr[AW-1:0]];

    // Storage and pointers. Reset clears the contents so that the heads read zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr <= '0;
            rptr <= '0;
            for (int i = 0; i < int'(D); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push && !full) begin
                mem[wptr[AW-1:0]] <= wdata;
                wptr              <= wptr + (AW+1)'(1);
            end
            if (pop && valid) begin
                rptr <= rptr + (AW+1)'(1);
            end
        end
    end
endmodule

module noc_route_decoder #(
    parameter int unsigned              DATA_W    = 9,
    parameter int unsigned              ADDR_W    = 4,
    parameter bit                       MODE      = 1'b1,
    parameter logic [ADDR_W-1:0]        NODE_ADDR = 4'b1000,
    parameter logic [ADDR_W-1:0]        NODE_MASK = 4'b1110,
    parameter int unsigned              DEPTH     = 2,
    parameter int unsigned              CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out0_data,
    output logic              out0_valid,
    input  logic              out0_ready,
    output logic [DATA_W-1:0] out1_data,
    output logic              out1_valid,
    input  logic              out1_ready,
    output logic              s_data,
    output logic              s_valid,
    input  logic              s_ready,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1
);
    localparam int unsigned LEVEL   = $countones(NODE_MASK);
    localparam int unsigned BIT_IDX = (LEVEL < ADDR_W) ? (ADDR_W - 1 - LEVEL) : 0;

    // Reject parameter sets that have no meaningful route bit or FIFO geometry.
    if (!MODE && (LEVEL >= ADDR_W)) begin : g_bad_level
        $error("noc_route_decoder: tree level equals address width");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("noc_route_decoder: DEPTH must be a power of 2 and >= 2");
    end

    logic [ADDR_W-1:0] addr_c;
    logic              route_c;
    logic              accept_c;
    logic              full0;
    logic              full1;
    logic              full_s;

    assign addr_c = in_data[DATA_W-1 -: ADDR_W];

    // Route bit: masked compare in leaf mode, level-selected address bit in tree mode.
    always_comb begin
        route_c = 1'b0;
        if (MODE) begin
            route_c = ((addr_c & NODE_MASK) != NODE_ADDR);
        end else begin
            route_c = addr_c[BIT_IDX];
        end
    end

    // Ready depends only on stored state, so any full FIFO stalls every flit.
    assign in_ready = reset_n && !full0 && !full1 && !full_s;
    assign accept_c = in_valid && in_ready;

    noc_route_fifo #(.W(DATA_W), .D(DEPTH)) u_fifo0 (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (accept_c && !route_c),
        .wdata   (in_data),
        .pop     (out0_ready),
        .rdata   (out0_data),
        .valid   (out0_valid),
        .full    (full0)
    );

    noc_route_fifo #(.W(DATA_W), .D(DEPTH)) u_fifo1 (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (accept_c && route_c),
        .wdata   (in_data),
        .pop     (out1_ready),
        .rdata   (out1_data),
        .valid   (out1_valid),
        .full    (full1)
    );

    noc_route_fifo #(.W(1), .D(2*DEPTH)) u_fifo_s (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (accept_c),
        .wdata   (route_c),
        .pop     (s_ready),
        .rdata   (s_data),
        .valid   (s_valid),
        .full    (full_s)
    );

    // Delivered-flit counters, wrapping modulo 2^CNT_W.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (out0_valid && out0_ready) cnt0 <= cnt0 + CNT_W'(1);
            if (out1_valid && out1_ready) cnt1 <= cnt1 + CNT_W'(1);
        end
    end
endmodule

// File: doc/noc_route_decoder.md
# noc_route_decoder

Clocked, parametrised successor to the two-way CSP route-decoder leaf of the asynchronous NoC. It accepts one flit per cycle on a valid/ready input and routes it to output port 0 or port 1, in either leaf mode (masked address compare) or tree mode (single address bit chosen by node level). For each accepted flit it also emits the route decision on a separate select channel. Per-port FIFOs decouple the ports, and per-port counters record delivered flits. It sits in the synchronous router fabric, one instance per decoder-tree node.

## Interface
- DATA_W, 9: flit width.
- ADDR_W, 4: width of the destination field. The field occupies in_data[DATA_W-1 : DATA_W-ADDR_W].
- MODE, 1: 1 = leaf compare, 0 = tree bit-select.
- NODE_ADDR, 4'b1000: node address used in leaf mode (ADDR_W bits).
- NODE_MASK, 4'b1110: address mask. In tree mode, its popcount L is the node level.
- DEPTH, 2: entries per output FIFO. Must be a power of 2 and at least 2.
- CNT_W, 16: delivered-flit counter width.

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_data  in  DATA_W  incoming flit.
- in_valid  in  1  flit offered.
- in_ready  out  1  decoder can accept.
- out0_data, out1_data  out  DATA_W  FIFO head per port.
- out0_valid, out1_valid  out  1  head valid.
- out0_ready, out1_ready  in  1  downstream accepts.
- s_data  out  1  route decision (0 = port 0, 1 = port 1).
- s_valid  out  1  decision valid.
- s_ready  in  1  decision consumed.
- cnt0, cnt1  out  CNT_W  flits delivered on each port.

## Operation
- Route function. Let A = in_data[DATA_W-1 : DATA_W-ADDR_W].
  - Leaf mode: port 0 if (A & NODE_MASK) == NODE_ADDR, otherwise port 1.
  - Tree mode: the route bit is A[ADDR_W-1-L]. 0 selects port 0; 1 selects port 1.
  - L == ADDR_W in tree mode is an elaboration error.
- Accept condition: in_valid && in_ready.
- On accept, in the same cycle:
  - in_data is pushed into the FIFO of the selected port.
  - The route bit is pushed into the S FIFO, which has depth 2*DEPTH.
- in_ready = !full0 && !full1 && !fullS.
  - It does not depend on in_data or in_valid.
  - A full port stalls the input even for flits bound to the other port. This is intentional; it keeps the ready path data-independent.
- Output channels:
  - out0, out1 and S each present their FIFO head. valid = FIFO non-empty.
  - Each pops on its own valid && ready, independently of the others.
  - Order of S entries equals acceptance order.
  - Order within each port is FIFO.
- Counters: cnt0 increments on out0_valid && out0_ready, and cnt1 likewise on port 1. Both wrap modulo 2^CNT_W without saturation.
- Simultaneous push and pop on the same FIFO: the occupancy count is unchanged and the data is correct, including at occupancy 1.
- Pointers are log2(depth) bits plus one wrap bit, and full/empty are derived from them. Wrap-around must be seamless across at least 3 full laps.

## Timing
- Reset (asynchronous assert, synchronous deassert handled upstream):
  - All FIFOs are emptied.
  - out*_valid = 0, s_valid = 0, cnt0 = cnt1 = 0.
  - out*_data and s_data are 0.
  - in_ready = 0 while reset_n is low, and 1 in the first cycle after release.
- Reset mid-transfer: stored flits are discarded, not delivered, and counters clear.
- Latency: a flit accepted at edge k has its outX_valid and s_valid high after edge k, and can be consumed at edge k+1. There is no combinational path from in_* to any output.
- Throughput: 1 flit/cycle sustained when all readies are high.
- Backpressure:
  - After DEPTH unconsumed flits on a port, in_ready falls after that edge.
  - It rises the cycle after the pop that frees an entry.
  - There is no same-cycle pop-to-push bypass when full.
- outX_data and s_data must remain stable while their valid is high and ready is low.

## Test plan
- Leaf mode with defaults:
  - Send 9'h120 (A = 1001). Expect out0_data = 9'h120 one cycle later, s_data = 0, and cnt0 = 1 after the pop.
  - Then send 9'h140 (A = 1010). Expect it on out1, s_data = 1.
- Tree mode, MODE = 0, NODE_MASK = 4'b1100 (L = 2, bit A[1]):
  - 9'h1A0 (A = 1101) goes to out0.
  - 9'h1C0 (A = 1110) goes to out1.
  - The S stream reads 0, 1.
- Backpressure: out0_ready = 0, DEPTH = 2, send three port-0 flits back to back.
  - The first two are accepted.
  - in_ready drops and holds the third, with out0_data stable.
  - Raising out0_ready for one cycle readmits the third flit on the following edge.
- Order and throughput: 64 random flits with all readies high.
  - One accept per cycle.
  - The S sequence matches the reference route model.
  - Per-port payload order is preserved.
  - Counters total 64.
- Wrap: CNT_W = 4, deliver 17 flits on port 1 (cnt1 = 1). Random ready toggling exercises FIFO pointer wrap with no lost or duplicated flit.
- Reset mid-stream: assert reset_n low with 2 flits queued on out0.
  - Valids drop immediately and counters read 0.
  - After release, a new flit 9'h120 appears alone on out0.
